// File: rtl/mat_mul_stream_ctrl_pkg.sv
// mat_mul_pkg: shared types and helpers for the mat_mul stream sequencer.
//   state_t    - sequencer states (LOAD_A, LOAD_B, START, WAIT, DRAIN)
//   n_a/n_b/n_c - element counts of A, B and C
//   elem_off   - bit offset of element idx in an MSB-first packed bus of n elements
//   cnt_w      - counter width for n elements (never below 1)
package mat_mul_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        DRAIN
    } state_t;

    function automatic int n_a(input int rows_a, input int cols_a);
        return rows_a * cols_a;
    endfunction

    function automatic int n_b(input int cols_a, input int cols_b);
        return cols_a * cols_b;
    endfunction

    function automatic int n_c(input int rows_a, input int cols_b);
        return rows_a * cols_b;
    endfunction

    // Element 0 sits in the top DATA_WIDTH bits, matching the core's
    // [0:R-1][0:C-1][W-1:0] declaration.
    function automatic int elem_off(input int idx, input int n, input int w);
        return (n - 1 - idx) * w;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_mul_stream_ctrl.sv
// mat_mul_stream_ctrl: stream-to-matrix sequencer in front of mat_mul_wrapper.
// Accepts A then B row-major on the s_* stream, packs them onto mm_a/mm_b,
// pulses mm_start, captures mm_c on mm_out_valid (acking with mm_out_ready)
// and streams C out row-major on m_* with m_last on the final element.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   s_valid/s_ready/s_data    - input element stream
//   m_valid/m_ready/m_data/m_last - output element stream
//   mm_a, mm_b, mm_start      - operands and start pulse to the core
//   mm_c, mm_out_valid, mm_out_ready - result and capture handshake
//   busy                      - a job is in flight
//   perf_cycles               - WAIT-cycle counter of the last job
// Build option: MAT_MUL_STREAM_CTRL_PERF_EN enables perf_cycles; otherwise 0.
module mat_mul_stream_ctrl
    import mat_mul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS_A     = 4,
    parameter int COLS_A     = 4,
    parameter int COLS_B     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [DATA_WIDTH-1:0]                s_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [DATA_WIDTH-1:0]                m_data,
    output logic                                 m_last,
    output logic [ROWS_A*COLS_A*DATA_WIDTH-1:0]  mm_a,
    output logic [COLS_A*COLS_B*DATA_WIDTH-1:0]  mm_b,
    output logic                                 mm_start,
    input  logic [ROWS_A*COLS_B*DATA_WIDTH-1:0]  mm_c,
    input  logic                                 mm_out_valid,
    output logic                                 mm_out_ready,
    output logic                                 busy,
    output logic [31:0]                          perf_cycles
);

    localparam int N_A = n_a(ROWS_A, COLS_A);
    localparam int N_B = n_b(COLS_A, COLS_B);
    localparam int N_C = n_c(ROWS_A, COLS_B);
    localparam int AW  = cnt_w(N_A);
    localparam int BW  = cnt_w(N_B);
    localparam int IW  = (AW > BW) ? AW : BW;
    localparam int KW  = cnt_w(N_C);

    localparam logic [IW-1:0] A_LAST = IW'(N_A - 1);
    localparam logic [IW-1:0] B_LAST = IW'(N_B - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N_C - 1);

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [KW-1:0]           k;
    logic [DATA_WIDTH-1:0]   a_mem [N_A];
    logic [DATA_WIDTH-1:0]   b_mem [N_B];
    logic [DATA_WIDTH-1:0]   c_mem [N_C];
    logic [DATA_WIDTH-1:0]   c_in  [N_C];

    // Fixed-position packing between element arrays and the core buses.
    for (genvar g = 0; g < N_A; g++) begin : g_pack_a
        assign mm_a[elem_off(g, N_A, DATA_WIDTH) +: DATA_WIDTH] = a_mem[g];
    end
    for (genvar g = 0; g < N_B; g++) begin : g_pack_b
        assign mm_b[elem_off(g, N_B, DATA_WIDTH) +: DATA_WIDTH] = b_mem[g];
    end
    for (genvar g = 0; g < N_C; g++) begin : g_unpack_c
        assign c_in[g] = mm_c[elem_off(g, N_C, DATA_WIDTH) +: DATA_WIDTH];
    end

    // Ack in the same cycle the result is seen, so the core never holds
    // out_valid for an extra cycle and the capture is exactly one beat.
    assign mm_out_ready = (state == WAIT) && mm_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD_A;
            idx      <= '0;
            k        <= '0;
            s_ready  <= 1'b1;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
            mm_start <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < N_A; i++) a_mem[i] <= '0;
            for (int i = 0; i < N_B; i++) b_mem[i] <= '0;
            for (int i = 0; i < N_C; i++) c_mem[i] <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (s_valid && s_ready) begin
                        a_mem[idx[AW-1:0]] <= s_data;
                        busy <= 1'b1;
                        if (idx == A_LAST) begin
                            idx   <= '0;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (s_valid && s_ready) begin
                        b_mem[idx[BW-1:0]] <= s_data;
                        if (idx == B_LAST) begin
                            // Start is issued from its own state, one cycle
                            // after the final B element lands.
                            idx      <= '0;
                            s_ready  <= 1'b0;
                            mm_start <= 1'b1;
                            state    <= START;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                START: begin
                    mm_start <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (mm_out_valid) begin
                        c_mem <= c_in;
                        k     <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!m_valid) begin
                        // First DRAIN cycle loads the output register.
                        m_valid <= 1'b1;
                        m_data  <= c_mem[k];
                        m_last  <= (k == K_LAST);
                    end else if (m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            k       <= '0;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                            state   <= LOAD_A;
                        end else begin
                            k      <= k + KW'(1);
                            m_data <= c_mem[k + KW'(1)];
                            m_last <= ((k + KW'(1)) == K_LAST);
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

`ifdef MAT_MUL_STREAM_CTRL_PERF_EN
    // Counts WAIT cycles including the capture cycle; saturating.
    logic [31:0] perf_q;
    always_ff @(posedge clk) begin
        if (rst)
            perf_q <= '0;
        else if (state == START)
            perf_q <= '0;
        else if (state == WAIT && perf_q != 32'hFFFF_FFFF)
            perf_q <= perf_q + 32'd1;
    end
    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mat_mul_stream_ctrl.sv
// Directed bench for mat_mul_stream_ctrl in a 2x2x2 shape with a model core
// that returns A*B three WAIT cycles after the start pulse.
module tb_mat_mul_stream_ctrl;
    localparam int DW = 32;
    localparam int R  = 2;
    localparam int K  = 2;
    localparam int C  = 2;
    localparam int NA = R * K;
    localparam int NB = K * C;
    localparam int NC = R * C;
    localparam int CORE_LAT = 3;
`ifdef MAT_MUL_STREAM_CTRL_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd3;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [DW-1:0]      s_data = '0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [DW-1:0]      m_data;
    logic               m_last;
    logic [NA*DW-1:0]   mm_a;
    logic [NB*DW-1:0]   mm_b;
    logic               mm_start;
    logic [NC*DW-1:0]   mm_c;
    logic               mm_out_valid;
    logic               mm_out_ready;
    logic               busy;
    logic [31:0]        perf_cycles;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mat_mul_stream_ctrl #(
        .DATA_WIDTH(DW), .ROWS_A(R), .COLS_A(K), .COLS_B(C)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .mm_a(mm_a), .mm_b(mm_b), .mm_start(mm_start),
        .mm_c(mm_c), .mm_out_valid(mm_out_valid), .mm_out_ready(mm_out_ready),
        .busy(busy), .perf_cycles(perf_cycles)
    );

    // Reference product from the packed operand buses (element 0 at MSB).
    function automatic logic [NC*DW-1:0] matmul(input logic [NA*DW-1:0] a,
                                                input logic [NB*DW-1:0] b);
        logic [NC*DW-1:0] r;
        logic [DW-1:0] av, bv, acc;
        r = '0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                acc = '0;
                for (int kk = 0; kk < K; kk++) begin
                    av  = DW'(a >> ((NA - 1 - (i * K + kk)) * DW));
                    bv  = DW'(b >> ((NB - 1 - (kk * C + j)) * DW));
                    acc = acc + av * bv;
                end
                r = r | ((NC*DW)'(acc) << ((NC - 1 - (i * C + j)) * DW));
            end
        return r;
    endfunction

    // Model core: result valid on the 3rd WAIT cycle, held until acked.
    int core_cnt;
    always @(posedge clk) begin
        if (rst) begin
            mm_out_valid <= 1'b0;
            mm_c         <= '0;
            core_cnt     <= 0;
        end else if (mm_out_valid && mm_out_ready) begin
            mm_out_valid <= 1'b0;
        end else if (mm_start) begin
            core_cnt <= 1;
        end else if (core_cnt != 0 && !mm_out_valid) begin
            if (core_cnt == CORE_LAT - 1) begin
                mm_out_valid <= 1'b1;
                mm_c         <= matmul(mm_a, mm_b);
                core_cnt     <= 0;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    // Event monitor: pulse counts and capture-to-output latency.
    int  cyc = 0;
    int  start_cnt = 0;
    int  ordy_cnt = 0;
    int  t_cap = 0;
    int  t_mv = 0;
    logic mv_prev = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mm_start) start_cnt <= start_cnt + 1;
        if (mm_out_ready) begin
            ordy_cnt <= ordy_cnt + 1;
            t_cap    <= cyc;
        end
        if (m_valid && !mv_prev) t_mv <= cyc;
        mv_prev <= m_valid;
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_ready) chk("send_timeout", 128'(n), 128'd0);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic load(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] v;
        v = a;
        for (int i = 0; i < NA; i++) begin
            send(v[127:96]);
            v = v << 32;
        end
        v = b;
        for (int i = 0; i < NB; i++) begin
            send(v[127:96]);
            v = v << 32;
        end
    endtask

    // Drains one result; checks every valid cycle (covers hold stability
    // under backpressure). dead=1 keeps 0xDEAD offered on the input.
    task automatic drain(input string tag, input logic [127:0] exp,
                         input bit bp, input bit dead);
        int pat [4] = '{1, 0, 0, 1};
        logic [127:0] e;
        int n, t;
        e = exp;
        n = 0;
        t = 0;
        while (n < NC && t < 200) begin
            m_ready = bp ? pat[t % 4][0] : 1'b1;
            if (dead) begin
                s_valid = 1'b1;
                s_data  = 32'hDEAD;
                chk($sformatf("%s_s_ready_busy", tag), 128'(s_ready), 128'd0);
            end
            if (m_valid) begin
                chk($sformatf("%s_data%0d", tag, n), 128'(m_data), 128'(e[127:96]));
                chk($sformatf("%s_last%0d", tag, n), 128'(m_last), 128'(n == NC - 1));
                if (m_ready) begin
                    n++;
                    e = e << 32;
                end
            end
            tick();
            t++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        if (n < NC) chk($sformatf("%s_drain_timeout", tag), 128'(n), 128'(NC));
        chk($sformatf("%s_s_ready_after", tag), 128'(s_ready), 128'd1);
        chk($sformatf("%s_busy_after", tag), 128'(busy), 128'd0);
        chk($sformatf("%s_m_valid_after", tag), 128'(m_valid), 128'd0);
    endtask

    int s0, o0, n_mv;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        // Reset state
        chk("rst_s_ready", 128'(s_ready), 128'd1);
        chk("rst_m_valid", 128'(m_valid), 128'd0);
        chk("rst_m_last", 128'(m_last), 128'd0);
        chk("rst_mm_start", 128'(mm_start), 128'd0);
        chk("rst_mm_out_ready", 128'(mm_out_ready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_perf", 128'(perf_cycles), 128'd0);
        chk("rst_mm_a", 128'(mm_a), 128'd0);
        chk("rst_mm_b", 128'(mm_b), 128'd0);

        // Job 1: {1,2,3,4} x {5,6,7,8} = {19,22,43,50}
        s0 = start_cnt;
        o0 = ordy_cnt;
        send(32'd1);
        chk("j1_busy_first", 128'(busy), 128'd1);
        send(32'd2); send(32'd3); send(32'd4);
        send(32'd5); send(32'd6); send(32'd7); send(32'd8);
        chk("j1_start_state_s_ready", 128'(s_ready), 128'd0);
        chk("j1_mm_start_pulse", 128'(mm_start), 128'd1);
        chk("j1_mm_a", 128'(mm_a), {32'd1, 32'd2, 32'd3, 32'd4});
        chk("j1_mm_b", 128'(mm_b), {32'd5, 32'd6, 32'd7, 32'd8});
        drain("j1", {32'd19, 32'd22, 32'd43, 32'd50}, 1'b0, 1'b0);
        chk("j1_start_count", 128'(start_cnt - s0), 128'd1);
        chk("j1_ordy_count", 128'(ordy_cnt - o0), 128'd1);
        chk("j1_cap_to_valid", 128'(t_mv - t_cap), 128'd2);
        chk("j1_perf", 128'(perf_cycles), 128'(PERF_EXP));
        chk("j1_mm_a_held", 128'(mm_a), {32'd1, 32'd2, 32'd3, 32'd4});

        // Job 2: identity x {1..4}, m_ready 1,0,0,1, 0xDEAD offered throughout
        s0 = start_cnt;
        o0 = ordy_cnt;
        load({32'd1, 32'd0, 32'd0, 32'd1}, {32'd1, 32'd2, 32'd3, 32'd4});
        drain("j2", {32'd1, 32'd2, 32'd3, 32'd4}, 1'b1, 1'b1);
        chk("j2_start_count", 128'(start_cnt - s0), 128'd1);
        chk("j2_ordy_count", 128'(ordy_cnt - o0), 128'd1);

        // Job 3 back-to-back: {2,0,1,3} x {1,1,0,2} = {2,2,1,7}
        load({32'd2, 32'd0, 32'd1, 32'd3}, {32'd1, 32'd1, 32'd0, 32'd2});
        chk("j3_mm_a_no_dead", 128'(mm_a), {32'd2, 32'd0, 32'd1, 32'd3});
        drain("j3", {32'd2, 32'd2, 32'd1, 32'd7}, 1'b0, 1'b0);
        chk("j3_perf", 128'(perf_cycles), 128'(PERF_EXP));

        // Reset during WAIT, then all-2s x identity
        load({32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8});
        tick();
        chk("j4_pre_rst_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("j4_rst_m_valid", 128'(m_valid), 128'd0);
        chk("j4_rst_s_ready", 128'(s_ready), 128'd1);
        chk("j4_rst_busy", 128'(busy), 128'd0);
        chk("j4_rst_mm_a", 128'(mm_a), 128'd0);
        chk("j4_rst_perf", 128'(perf_cycles), 128'd0);
        n_mv = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_valid) n_mv++;
            tick();
        end
        chk("j4_no_stale_valid", 128'(n_mv), 128'd0);
        load({32'd2, 32'd2, 32'd2, 32'd2}, {32'd1, 32'd0, 32'd0, 32'd1});
        drain("j4", {32'd2, 32'd2, 32'd2, 32'd2}, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
